// File: rtl/fixed_huf_pkg.sv
// Shared definitions for the Deflate fixed-Huffman encoder.
// Contents: FSM state enum, RFC1951 length/distance base and extra-bit
// tables, block header and EOB constants, the literal/length code mapper
// and a variable-width bit reverse.
package fixed_huf_pkg;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DIST, S_EOB} state_t;

  // BFINAL=1, BTYPE=01, already reversed for the MSB-first packer.
  localparam logic [2:0] HDR_DAT = 3'b110;
  localparam logic [4:0] HDR_NB  = 5'd3;
  // End-of-block is symbol 256: 7 zero bits.
  localparam logic [6:0] EOB_DAT = 7'd0;
  localparam logic [4:0] EOB_NB  = 5'd7;

  // Length symbols 257..285.
  localparam logic [8:0] LEN_BASE [0:28] = '{
    9'd3,   9'd4,   9'd5,   9'd6,   9'd7,   9'd8,   9'd9,   9'd10,
    9'd11,  9'd13,  9'd15,  9'd17,  9'd19,  9'd23,  9'd27,  9'd31,
    9'd35,  9'd43,  9'd51,  9'd59,  9'd67,  9'd83,  9'd99,  9'd115,
    9'd131, 9'd163, 9'd195, 9'd227, 9'd258};
  localparam logic [2:0] LEN_EXT [0:28] = '{
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
    3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4,
    3'd5, 3'd5, 3'd5, 3'd5, 3'd0};

  // Distance codes 0..29.
  localparam logic [15:0] DST_BASE [0:29] = '{
    16'd1,    16'd2,    16'd3,     16'd4,     16'd5,     16'd7,
    16'd9,    16'd13,   16'd17,    16'd25,    16'd33,    16'd49,
    16'd65,   16'd97,   16'd129,   16'd193,   16'd257,   16'd385,
    16'd513,  16'd769,  16'd1025,  16'd1537,  16'd2049,  16'd3073,
    16'd4097, 16'd6145, 16'd8193,  16'd12289, 16'd16385, 16'd24577};
  localparam logic [3:0] DST_EXT [0:29] = '{
    4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd2,  4'd2,  4'd3,  4'd3,
    4'd4,  4'd4,  4'd5,  4'd5,  4'd6,  4'd6,  4'd7,  4'd7,  4'd8,  4'd8,
    4'd9,  4'd9,  4'd10, 4'd10, 4'd11, 4'd11, 4'd12, 4'd12, 4'd13, 4'd13};

  typedef struct packed {
    logic [8:0] code;
    logic [4:0] nb;
  } huf_t;

  // Fixed literal/length code for symbol 0..287 (emitted unreversed).
  function automatic huf_t huf_code(input logic [8:0] s);
    huf_t h;
    if (s < 9'd144) begin
      h.code = 9'h030 + s;            h.nb = 5'd8;
    end else if (s < 9'd256) begin
      h.code = 9'h190 + (s - 9'd144); h.nb = 5'd9;
    end else if (s < 9'd280) begin
      h.code = s - 9'd256;            h.nb = 5'd7;
    end else begin
      h.code = 9'h0C0 + (s - 9'd280); h.nb = 5'd8;
    end
    return h;
  endfunction

  // Reverse the low n bits of v (n <= 13); upper result bits are zero.
  function automatic logic [12:0] rev13(input logic [12:0] v, input logic [3:0] n);
    logic [12:0] r;
    for (int i = 0; i < 13; i++) r[i] = v[12-i];
    return r >> (4'd13 - n);
  endfunction

endpackage

// File: rtl/fixed_huf_lut.sv
// Combinational table lookup for match tokens.
//   len      : match length 3..258 -> len_sym (257..285), extra value/count
//   dst      : distance 1..32768   -> dst_code (0..29),   extra value/count
// Extra values are returned in natural bit order; the parent reverses them.
module fixed_huf_lut
  import fixed_huf_pkg::*;
(
  input  logic [8:0]  len,
  input  logic [15:0] dst,
  output logic [8:0]  len_sym,
  output logic [4:0]  len_eval,
  output logic [2:0]  len_ecnt,
  output logic [4:0]  dst_code,
  output logic [12:0] dst_eval,
  output logic [3:0]  dst_ecnt
);

  logic [4:0] li, di;

  // Largest base not exceeding the input selects the entry; 258 lands on
  // symbol 285 rather than 284+31 because its base is searched last.
  always_comb begin
    li = '0;
    for (int i = 0; i < 29; i++) if (len >= LEN_BASE[i]) li = 5'(i);
    di = '0;
    for (int i = 0; i < 30; i++) if (dst >= DST_BASE[i]) di = 5'(i);
    len_sym  = 9'd257 + {4'd0, li};
    len_eval = 5'(len - LEN_BASE[li]);
    len_ecnt = LEN_EXT[li];
    dst_code = di;
    dst_eval = 13'(dst - DST_BASE[di]);
    dst_ecnt = DST_EXT[di];
  end

endmodule

// File: rtl/fixed_huf_enc.sv
// Deflate fixed-Huffman (BTYPE=01) symbol encoder.
// Turns LZ77 tokens and block start/end pulses into right-aligned bit fields
// (val_o, dat_o, numb_o = bits-1) for an MSB-first packer. Header and extra
// bits are bit-reversed here; Huffman codes are not.
// Ports: clk, rst (async, active high); sta_i/end_i block commands;
//   tok_val_i/tok_rdy_o handshake with tok_typ_i/lit/len/dst payload;
//   val_o/dat_o/numb_o field output; done_o pulses with the EOB field.
// Build option: FIXED_HUF_MERGE_EN emits length+distance as one field.
module fixed_huf_enc
  import fixed_huf_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int NUMB_WD = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sta_i,
  input  logic               end_i,
  input  logic               tok_val_i,
  output logic               tok_rdy_o,
  input  logic               tok_typ_i,
  input  logic [7:0]         tok_lit_i,
  input  logic [8:0]         tok_len_i,
  input  logic [15:0]        tok_dst_i,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic [NUMB_WD-1:0] numb_o,
  output logic               done_o
);

  state_t state_q, cur, nxt;
  logic   pend_q, pend_d;
  logic   val_d, done_d;
  logic [31:0] fld;
  logic [4:0]  nb;

  logic [8:0]  len_sym;
  logic [4:0]  len_eval;
  logic [2:0]  len_ecnt;
  logic [4:0]  dst_code;
  logic [12:0] dst_eval;
  logic [3:0]  dst_ecnt;

  fixed_huf_lut u_lut (
    .len(tok_len_i), .dst(tok_dst_i),
    .len_sym(len_sym), .len_eval(len_eval), .len_ecnt(len_ecnt),
    .dst_code(dst_code), .dst_eval(dst_eval), .dst_ecnt(dst_ecnt)
  );

  huf_t        lit_h, len_h;
  logic [31:0] len_fld, dst_fld;
  logic [4:0]  len_nb, dst_nb;

  always_comb begin
    lit_h   = huf_code({1'b0, tok_lit_i});
    len_h   = huf_code(len_sym);
    len_fld = (32'(len_h.code) << len_ecnt) | 32'(rev13(13'(len_eval), 4'(len_ecnt)));
    len_nb  = len_h.nb + 5'(len_ecnt);
    dst_fld = (32'(dst_code) << dst_ecnt) | 32'(rev13(dst_eval, dst_ecnt));
    dst_nb  = 5'd5 + 5'(dst_ecnt);
  end

  assign tok_rdy_o = (state_q == S_DATA) && !pend_q;
  wire   acc       = tok_val_i && tok_rdy_o;

`ifndef FIXED_HUF_MERGE_EN
  // Distance field is resolved at accept time so the token inputs are free
  // to change while DIST drains it.
  logic [17:0] dfld_q;
  logic [4:0]  dnb_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dfld_q <= '0;
      dnb_q  <= '0;
    end else if (acc && tok_typ_i) begin
      dfld_q <= 18'(dst_fld);
      dnb_q  <= dst_nb;
    end
  end
`endif

  always_comb begin
    // HDR lasts zero cycles: the header is registered on the sta_i edge so
    // a token can already be accepted while the header is on the output.
    cur = (state_q == S_IDLE && sta_i) ? S_HDR : state_q;
    nxt    = cur;
    pend_d = pend_q;
    val_d  = 1'b0;
    done_d = 1'b0;
    fld    = '0;
    nb     = 5'd1;
    if (end_i && (cur == S_HDR || cur == S_DATA || cur == S_DIST)) pend_d = 1'b1;
    case (cur)
      S_HDR: begin
        val_d = 1'b1; fld = 32'(HDR_DAT); nb = HDR_NB; nxt = S_DATA;
      end
      S_DATA: begin
        if (acc && !tok_typ_i) begin
          val_d = 1'b1; fld = 32'(lit_h.code); nb = lit_h.nb;
        end else if (acc) begin
          val_d = 1'b1;
`ifdef FIXED_HUF_MERGE_EN
          fld = (len_fld << dst_nb) | dst_fld;
          nb  = len_nb + dst_nb;
`else
          fld = len_fld;
          nb  = len_nb;
          nxt = S_DIST;
`endif
        end else if (pend_q) begin
          nxt = S_EOB;
        end
      end
`ifndef FIXED_HUF_MERGE_EN
      S_DIST: begin
        val_d = 1'b1; fld = 32'(dfld_q); nb = dnb_q; nxt = S_DATA;
      end
`endif
      S_EOB: begin
        val_d = 1'b1; done_d = 1'b1; fld = 32'(EOB_DAT); nb = EOB_NB;
        pend_d = 1'b0; nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      val_o   <= 1'b0;
      dat_o   <= '0;
      numb_o  <= '0;
      done_o  <= 1'b0;
    end else begin
      state_q <= nxt;
      pend_q  <= pend_d;
      val_o   <= val_d;
      done_o  <= done_d;
      dat_o   <= val_d ? DATA_WD'(fld) : '0;
      numb_o  <= val_d ? NUMB_WD'(nb - 5'd1) : '0;
    end
  end

endmodule

// File: tb/tb_fixed_huf_enc.sv
module tb_fixed_huf_enc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sta_i = 0, end_i = 0, tok_val_i = 0, tok_typ_i = 0;
  logic [7:0]  tok_lit_i = 0;
  logic [8:0]  tok_len_i = 0;
  logic [15:0] tok_dst_i = 0;
  logic        tok_rdy_o, val_o, done_o;
  logic [31:0] dat_o;
  logic [4:0]  numb_o;

  int vecs = 0;
  int errs = 0;

  fixed_huf_enc #(.DATA_WD(32), .NUMB_WD(5)) dut (
    .clk(clk), .rst(rst), .sta_i(sta_i), .end_i(end_i),
    .tok_val_i(tok_val_i), .tok_rdy_o(tok_rdy_o), .tok_typ_i(tok_typ_i),
    .tok_lit_i(tok_lit_i), .tok_len_i(tok_len_i), .tok_dst_i(tok_dst_i),
    .val_o(val_o), .dat_o(dat_o), .numb_o(numb_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    vecs++;
    if ({val_o, numb_o, dat_o, done_o, tok_rdy_o} !== 40'd0) begin
      errs++; $display("FAIL reset: got val=%b numb=%0d dat=%h done=%b rdy=%b want all 0",
                       val_o, numb_o, dat_o, done_o, tok_rdy_o);
    end
    step(); rst = 0; step();
  endtask

  task automatic test_header();
    sta_i = 1; step(); sta_i = 0;
    vecs++;
    if ({val_o, numb_o, dat_o, tok_rdy_o} !== {1'b1, 5'd2, 32'h6, 1'b1}) begin
      errs++; $display("FAIL header: got val=%b numb=%0d dat=%h rdy=%b want 1/2/6/1",
                       val_o, numb_o, dat_o, tok_rdy_o);
    end
  endtask

  task automatic test_sta_ignored();
    sta_i = 1; step(); sta_i = 0;
    vecs++;
    if ({val_o, tok_rdy_o} !== 2'b01) begin
      errs++; $display("FAIL sta_in_data: got val=%b rdy=%b want 0/1", val_o, tok_rdy_o);
    end
  endtask

  task automatic lit(input logic [7:0] l, input logic [4:0] en, input logic [31:0] ed,
                     input string name);
    tok_val_i = 1; tok_typ_i = 0; tok_lit_i = l; step(); tok_val_i = 0;
    vecs++;
    if ({val_o, numb_o, dat_o} !== {1'b1, en, ed}) begin
      errs++; $display("FAIL %s: got val=%b numb=%0d dat=%h want 1/%0d/%h",
                       name, val_o, numb_o, dat_o, en, ed);
    end
  endtask

  task automatic test_literals();
    lit(8'h41, 5'd7, 32'h71, "lit_41");
    lit(8'd200, 5'd8, 32'h1C8, "lit_200");
  endtask

  // Expected values are the separate length and distance fields; with the
  // merge build the bench joins them itself.
  task automatic match(input logic [8:0] l, input logic [15:0] d,
                       input logic [4:0] ln, input logic [31:0] lf,
                       input logic [4:0] dn, input logic [31:0] df, input string name);
    tok_val_i = 1; tok_typ_i = 1; tok_len_i = l; tok_dst_i = d; step(); tok_val_i = 0;
`ifdef FIXED_HUF_MERGE_EN
    vecs++;
    if ({val_o, numb_o, dat_o, tok_rdy_o} !== {1'b1, 5'(ln + dn + 1), (lf << (dn + 1)) | df, 1'b1}) begin
      errs++; $display("FAIL %s_merged: got val=%b numb=%0d dat=%h rdy=%b",
                       name, val_o, numb_o, dat_o, tok_rdy_o);
    end
`else
    vecs++;
    if ({val_o, numb_o, dat_o, tok_rdy_o} !== {1'b1, ln, lf, 1'b0}) begin
      errs++; $display("FAIL %s_len: got val=%b numb=%0d dat=%h rdy=%b want 1/%0d/%h/0",
                       name, val_o, numb_o, dat_o, tok_rdy_o, ln, lf);
    end
    step();
    vecs++;
    if ({val_o, numb_o, dat_o, tok_rdy_o} !== {1'b1, dn, df, 1'b1}) begin
      errs++; $display("FAIL %s_dst: got val=%b numb=%0d dat=%h rdy=%b want 1/%0d/%h/1",
                       name, val_o, numb_o, dat_o, tok_rdy_o, dn, df);
    end
`endif
  endtask

  task automatic test_matches();
    match(9'd3,   16'd1,     5'd6, 32'h01, 5'd4,  32'h00,    "m3_1");
    match(9'd12,  16'd5,     5'd7, 32'h13, 5'd5,  32'h08,    "m12_5");
    match(9'd258, 16'd32768, 5'd7, 32'hC5, 5'd17, 32'h3BFFF, "m258_32768");
    // Multi-bit extras: len 20 -> sym 269 extra 01 -> 10; dst 10 -> code 6 extra 01 -> 10.
    match(9'd20,  16'd10,    5'd8, 32'h36, 5'd6,  32'h1A,    "m20_10");
  endtask

  task automatic test_back_to_back();
    tok_val_i = 1; tok_typ_i = 0;
    tok_lit_i = 8'd144; step();
    vecs++;
    if ({val_o, numb_o, dat_o} !== {1'b1, 5'd8, 32'h190}) begin
      errs++; $display("FAIL b2b_144: got val=%b numb=%0d dat=%h", val_o, numb_o, dat_o);
    end
    tok_lit_i = 8'd143; step();
    vecs++;
    if ({val_o, numb_o, dat_o} !== {1'b1, 5'd7, 32'hBF}) begin
      errs++; $display("FAIL b2b_143: got val=%b numb=%0d dat=%h", val_o, numb_o, dat_o);
    end
    tok_lit_i = 8'd255; step();
    vecs++;
    if ({val_o, numb_o, dat_o} !== {1'b1, 5'd8, 32'h1FF}) begin
      errs++; $display("FAIL b2b_255: got val=%b numb=%0d dat=%h", val_o, numb_o, dat_o);
    end
    // Match followed by a literal held valid: the literal must wait out DIST.
    tok_typ_i = 1; tok_len_i = 9'd3; tok_dst_i = 16'd1; step();
    tok_typ_i = 0; tok_lit_i = 8'h41;
`ifndef FIXED_HUF_MERGE_EN
    step();
    vecs++;
    if ({val_o, numb_o, dat_o} !== {1'b1, 5'd4, 32'h0}) begin
      errs++; $display("FAIL b2b_dist_hold: got val=%b numb=%0d dat=%h want 1/4/0",
                       val_o, numb_o, dat_o);
    end
`endif
    step(); tok_val_i = 0;
    vecs++;
    if ({val_o, numb_o, dat_o} !== {1'b1, 5'd7, 32'h71}) begin
      errs++; $display("FAIL b2b_lit_after_match: got val=%b numb=%0d dat=%h want 1/7/71",
                       val_o, numb_o, dat_o);
    end
  endtask

  task automatic test_end();
    bit seen = 0;
    tok_val_i = 1; tok_typ_i = 0; tok_lit_i = 8'h00; end_i = 1; step();
    tok_val_i = 0; end_i = 0;
    vecs++;
    if ({val_o, numb_o, dat_o, tok_rdy_o} !== {1'b1, 5'd7, 32'h30, 1'b0}) begin
      errs++; $display("FAIL end_lit: got val=%b numb=%0d dat=%h rdy=%b want 1/7/30/0",
                       val_o, numb_o, dat_o, tok_rdy_o);
    end
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      if (done_o) seen = 1;
    end
    vecs++;
    if (!seen || {val_o, numb_o, dat_o} !== {1'b1, 5'd6, 32'h0}) begin
      errs++; $display("FAIL eob: got seen=%b val=%b numb=%0d dat=%h want 1/1/6/0",
                       seen, val_o, numb_o, dat_o);
    end
    step();
    vecs++;
    if ({val_o, done_o, tok_rdy_o} !== 3'b000) begin
      errs++; $display("FAIL after_eob: got val=%b done=%b rdy=%b want 0/0/0",
                       val_o, done_o, tok_rdy_o);
    end
    // In IDLE, tokens and end_i are ignored.
    tok_val_i = 1; end_i = 1; step(); step();
    tok_val_i = 0; end_i = 0;
    vecs++;
    if ({val_o, done_o, tok_rdy_o} !== 3'b000) begin
      errs++; $display("FAIL idle_ignore: got val=%b done=%b rdy=%b want 0/0/0",
                       val_o, done_o, tok_rdy_o);
    end
  endtask

  task automatic test_reset_in_dist();
    sta_i = 1; step(); sta_i = 0;
    tok_val_i = 1; tok_typ_i = 1; tok_len_i = 9'd3; tok_dst_i = 16'd1; step();
    tok_val_i = 0;
    rst = 1; #1;
    vecs++;
    if ({val_o, numb_o, dat_o, done_o, tok_rdy_o} !== 40'd0) begin
      errs++; $display("FAIL rst_dist_now: got val=%b numb=%0d dat=%h done=%b rdy=%b want 0",
                       val_o, numb_o, dat_o, done_o, tok_rdy_o);
    end
    step(); rst = 0; step(); step();
    vecs++;
    if ({val_o, tok_rdy_o} !== 2'b00) begin
      errs++; $display("FAIL rst_dist_after: got val=%b rdy=%b want 0/0", val_o, tok_rdy_o);
    end
  endtask

  initial begin
    test_reset();
    test_header();
    test_sta_ignored();
    test_literals();
    test_matches();
    test_back_to_back();
    test_end();
    test_reset_in_dist();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fixed_huf_enc.md
Name: fixed_huf_enc

Overview:
- Deflate fixed-Huffman (BTYPE=01) symbol encoder in the zlib path.
- Takes LZ77 tokens (literal or length/distance match) plus block start/end commands.
- Emits variable-length bit fields as (val_o, dat_o, numb_o) for the bit packer directly downstream.
- The packer appends MSB-first and byte-reverses later, so this block bit-reverses deflate LSB-first fields: block header and extra bits. Huffman codes are emitted unreversed.

Parameters:
- DATA_WD, 32, output field width; fields are right-aligned in dat_o.
- NUMB_WD, 5, numb_o width; value = valid bits - 1.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- sta_i  input  1  pulse: start block (emit header).
- end_i  input  1  pulse: end block (emit EOB).
- tok_val_i  input  1  token valid.
- tok_rdy_o  output  1  token ready.
- tok_typ_i  input  1  0=literal, 1=match.
- tok_lit_i  input  8  literal byte.
- tok_len_i  input  9  match length, 3..258.
- tok_dst_i  input  16  match distance, 1..32768.
- val_o  output  1  field valid, one cycle per field.
- dat_o  output  DATA_WD  field bits, right-aligned; upper bits zero.
- numb_o  output  NUMB_WD  field bit count minus 1.
- done_o  output  1  pulse, coincides with the EOB field.

Behaviour:
- Reset: val_o=0, dat_o=0, numb_o=0, done_o=0, tok_rdy_o=0; FSM=IDLE; end-pending=0. Reset mid-operation discards the in-flight token.
- Outputs are registered. Every field appears exactly 1 cycle after its cause.
- Downstream has no backpressure; val_o may assert every cycle.
- FSM IDLE:
  - sta_i -> HDR.
  - end_i and tokens are ignored.
- FSM HDR:
  - Emit header: numb_o=2, dat_o=3'b110 (BFINAL=1, BTYPE=01, reversed).
  - Go to DATA.
- FSM DATA:
  - tok_rdy_o = ~end-pending.
  - Literal accepted (val&rdy): emit code next cycle; stay in DATA.
  - Match accepted: emit length field next cycle; go to DIST.
  - Otherwise, if end-pending: go to EOB.
- FSM DIST:
  - tok_rdy_o=0.
  - Emit distance field (token latched at accept); return to DATA.
- FSM EOB:
  - Emit numb_o=6, dat_o=0, done_o=1.
  - Clear end-pending; go to IDLE.
- end_i in HDR/DATA/DIST sets end-pending. EOB is emitted only after the current token completes, so end_i never pre-empts a token accepted in the same cycle.
- sta_i outside IDLE is ignored.
- Literal/length codes:
  - 0..143: 8 bits, 0x30+s.
  - 144..255: 9 bits, 0x190+(s-144).
  - 256..279: 7 bits, s-256.
  - 280..287: 8 bits, 0xC0+(s-280).
- Length field = {code, reverse(extra)}, 7..13 bits total.
- Length symbols follow RFC1951 table: 3..10 -> 257..264 (0 extra) through 258 -> 285 (0 extra).
- Distance field = {5-bit dist code, reverse(extra)}, 5..18 bits; dist codes 0..29 per RFC1951.
- Out-of-range len/dst is not checked; output is unspecified but the FSM must still return to DATA.

Optional Feature:
- FIXED_HUF_MERGE_EN defined: a match emits one field {length field, distance field} (max 31 bits) in one cycle. DIST state is unused, and tok_rdy_o stays high through matches.
- Not defined: two-cycle match as above.

Decomposition:
- Package fixed_huf_pkg holds:
  - FSM state enum.
  - Base/extra tables for length and distance.
  - Header constant 3'b110.
  - EOB constants.
- One combinational sub-module, fixed_huf_lut: maps len -> {sym, extra value, extra count} and dst -> {code, extra value, extra count}. Bit reversal is done in the parent.

Test Plan:
- sta_i pulse in IDLE -> next cycle val_o=1, numb_o=2, dat_o=0x6; FSM in DATA, tok_rdy_o=1.
- Literal 0x41 -> numb_o=7, dat_o=0x71. Literal 200 -> numb_o=8, dat_o=0x1C8. Back-to-back literals -> val_o high every cycle.
- Match len=3 dst=1 -> field1 numb_o=6, dat_o=0x01; field2 numb_o=4, dat_o=0x00; tok_rdy_o low one cycle.
- Match len=12 dst=5 -> numb_o=7, dat_o=0x13; then numb_o=5, dat_o=0x08. Match len=258 dst=32768 -> numb_o=7, dat_o=0xC5; then numb_o=17, dat_o=0x3BFFF.
- end_i in the same cycle as an accepted literal 0x00 -> dat_o=0x30 (numb_o=7); then EOB numb_o=6, dat_o=0, done_o=1; then IDLE, tok_rdy_o=0.
- Assert rst during DIST -> all outputs 0 immediately; no distance field emitted after release. With FIXED_HUF_MERGE_EN, len=3 dst=1 -> single field numb_o=11, dat_o=0x020.
